// File: rtl/eth_tx_framer.sv
// eth_tx_framer
//   Builds an Ethernet frame into a byte-addressed transmit buffer:
//   destination MAC, fixed source MAC, EtherType, then payload bytes
//   taken from a valid/ready stream. Short frames can be zero-padded
//   to the 60-byte minimum.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset, aborts any frame
//   start      frame request, sampled only while idle
//   dst_mac    destination MAC ([47:40] sent first), sampled with start
//   ethertype  EtherType ([15:8] sent first), sampled with start
//   len        payload byte count 0..1500, sampled with start
//   pl_d       payload byte
//   pl_valid   pl_d valid
//   pl_ready   framer takes a payload byte this cycle
//   tx_d       byte written to the buffer (0x00 when tx_we=0)
//   tx_a       buffer address (never above 1513)
//   tx_we      buffer write strobe, one byte per cycle
//   busy       frame in progress
//   done       one-cycle completion pulse
//   err        one-cycle pulse when a start with len>1500 is rejected
//   frame_len  bytes written for the last completed frame
//
// Build option
//   ETH_TX_PAD_EN  defined: pad short frames with 0x00 up to 60 bytes.
//                  undefined: no padding, frame_len = 14 + len.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for start; rejects oversize requests
// DST     | writing destination MAC, addresses 0..5
// SRC     | writing own MAC, addresses 6..11
// TYPE    | writing EtherType, addresses 12..13
// PAYLOAD | copying payload bytes on pl_valid & pl_ready
// PAD     | writing 0x00 up to address 59 (ETH_TX_PAD_EN only)
// FIN     | done pulse, frame_len updated, back to IDLE

module eth_tx_framer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [15:0] ethertype,
  input  logic [10:0] len,
  input  logic [7:0]  pl_d,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  tx_d,
  output logic [10:0] tx_a,
  output logic        tx_we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] frame_len
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_PAD,
    S_FIN
  } state_t;

  // Must match the address accepted by the receive-side filter.
  localparam logic [47:0] OWN_MAC  = 48'hFEFA_F6F2_EEEA;
  localparam logic [10:0] MAX_LEN  = 11'd1500;
  localparam logic [10:0] DST_LAST = 11'd5;
  localparam logic [10:0] SRC_LAST = 11'd11;
  localparam logic [10:0] HDR_LAST = 11'd13;
`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] MIN_LAST = 11'd59;
`endif

  state_t      r_state;
  logic [47:0] r_dst;
  logic [47:0] r_src;
  logic [15:0] r_type;
  logic [10:0] r_remain;
  logic [10:0] r_addr;
  logic [10:0] r_frame_len;
  logic        r_pl_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic [10:0] w_addr_nxt;
  logic        w_take;
  logic        w_we;
  logic [7:0]  w_d;

  assign w_addr_nxt = r_addr + 11'd1;
  assign w_take     = r_pl_ready & pl_valid;

  // Header fields are held in shift registers so the outgoing byte is
  // always the top byte; no address-indexed mux is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dst       <= '0;
      r_src       <= '0;
      r_type      <= '0;
      r_remain    <= '0;
      r_addr      <= '0;
      r_frame_len <= '0;
      r_pl_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (len > MAX_LEN) begin
              r_err <= 1'b1;
            end else begin
              r_dst    <= dst_mac;
              r_src    <= OWN_MAC;
              r_type   <= ethertype;
              r_remain <= len;
              r_addr   <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_DST;
            end
          end
        end
        S_DST: begin
          r_dst  <= {r_dst[39:0], 8'h00};
          r_addr <= w_addr_nxt;
          if (r_addr == DST_LAST) r_state <= S_SRC;
        end
        S_SRC: begin
          r_src  <= {r_src[39:0], 8'h00};
          r_addr <= w_addr_nxt;
          if (r_addr == SRC_LAST) r_state <= S_TYPE;
        end
        S_TYPE: begin
          r_type <= {r_type[7:0], 8'h00};
          if (r_addr != HDR_LAST) begin
            r_addr <= w_addr_nxt;
          end else if (r_remain != 11'd0) begin
            r_addr     <= w_addr_nxt;
            r_pl_ready <= 1'b1;
            r_state    <= S_PAYLOAD;
          end else begin
`ifdef ETH_TX_PAD_EN
            r_addr  <= w_addr_nxt;
            r_state <= S_PAD;
`else
            // Address stays on the last written byte so tx_a never
            // runs past the frame.
            r_frame_len <= w_addr_nxt;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_FIN;
`endif
          end
        end
        S_PAYLOAD: begin
          if (w_take) begin
            r_remain <= r_remain - 11'd1;
            if (r_remain != 11'd1) begin
              r_addr <= w_addr_nxt;
            end else begin
              r_pl_ready <= 1'b0;
`ifdef ETH_TX_PAD_EN
              if (r_addr < MIN_LAST) begin
                r_addr  <= w_addr_nxt;
                r_state <= S_PAD;
              end else begin
                r_frame_len <= w_addr_nxt;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= S_FIN;
              end
`else
              r_frame_len <= w_addr_nxt;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_FIN;
`endif
            end
          end
        end
`ifdef ETH_TX_PAD_EN
        S_PAD: begin
          if (r_addr == MIN_LAST) begin
            r_frame_len <= w_addr_nxt;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_FIN;
          end else begin
            r_addr <= w_addr_nxt;
          end
        end
`endif
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Write strobe and data are decoded from state; the payload path is a
  // straight pass-through so the byte lands in the handshake cycle.
  always_comb begin
    w_we = 1'b0;
    w_d  = 8'h00;
    case (r_state)
      S_DST: begin
        w_we = 1'b1;
        w_d  = r_dst[47:40];
      end
      S_SRC: begin
        w_we = 1'b1;
        w_d  = r_src[47:40];
      end
      S_TYPE: begin
        w_we = 1'b1;
        w_d  = r_type[15:8];
      end
      S_PAYLOAD: begin
        if (w_take) begin
          w_we = 1'b1;
          w_d  = pl_d;
        end
      end
`ifdef ETH_TX_PAD_EN
      S_PAD: begin
        w_we = 1'b1;
        w_d  = 8'h00;
      end
`endif
      default: begin
        w_we = 1'b0;
        w_d  = 8'h00;
      end
    endcase
  end

  assign pl_ready  = r_pl_ready;
  assign tx_d      = w_d;
  assign tx_a      = r_addr;
  assign tx_we     = w_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign frame_len = r_frame_len;

endmodule
